wasm_code_loader: RTL and testbench
===================================

// Module: wasm_code_loader
// PURPOSE
//   Writer side of the CPU program ROM: accepts a WebAssembly binary as a byte
//   stream and writes it into program memory at sequential addresses.
//   Checks the 8-byte module header ("\0asm", version 1) and holds the CPU in
//   reset until the image is fully loaded. Sits between the host byte link and
//   the cpu's program-memory write port.
// PARAMETERS
//   ADDR_WIDTH   16  program-memory address width (bytes)
//   START_ADDR   0   address written by the first byte
//   CHECK_HEADER 1   1: validate magic/version; 0: accept any bytes
// PORTS
//   clk        in   1           system clock
//   reset      in   1           synchronous, active-high reset
//   in_data    in   8           stream byte
//   in_valid   in   1           in_data valid
//   in_last    in   1           qualifies in_data as final byte of image
//   in_ready   out  1           loader accepts a byte this cycle
//   restart    in   1           from DONE/ERROR: begin new load
//   mem_addr   out  ADDR_WIDTH  program-memory write address
//   mem_data   out  8           program-memory write data
//   mem_we     out  1           write strobe, one cycle per byte
//   cpu_reset  out  1           hold cpu in reset while loading
//   done       out  1           image loaded, cpu released
//   error      out  3           0 none, 1 bad magic, 2 bad version,
//                               3 overflow, 4 truncated header
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset values: state=HEADER, index=0, addr=START_ADDR, mem_we=0,
//   mem_addr=START_ADDR, mem_data=0, cpu_reset=1, done=0, error=0.
// - Byte accepted on a cycle with in_valid && in_ready.
// - in_ready=1 in HEADER and BODY; 0 in DONE and ERROR.
// - Write latency: byte accepted in cycle N -> mem_we=1 in N+1, with
//   mem_addr/mem_data for that byte. mem_we is 0 in every other cycle.
// - Header bytes are written too, so code starts at START_ADDR+8.
// - HEADER: byte index 0..7 compared with 00 61 73 6D 01 00 00 00.
//   index 0-3 mismatch -> error=1; index 4-7 mismatch -> error=2.
//   On a mismatch: go to ERROR; the bad byte is not written.
//   in_last at index<7 -> error=4, ERROR; byte is still checked first.
//   Index 7 accepted without in_last -> BODY.
//   Index 7 accepted with in_last -> DONE.
// - BODY: each byte written. in_last -> DONE.
// - Overflow: byte accepted when addr = 2^ADDR_WIDTH-1 without in_last.
//   That byte is written; the next accepted byte gives error=3, ERROR, and
//   is not written. No wrap-around is ever written.
// - DONE: done=1 and cpu_reset=0 from the cycle after the final byte's
//   mem_we, i.e. 2 cycles after acceptance of the final byte.
// - ERROR: error held; cpu_reset stays 1; done=0.
// - restart in DONE/ERROR: next cycle state=HEADER, addr=START_ADDR,
//   error=0, done=0, cpu_reset=1. restart ignored in HEADER/BODY.
// - Reset mid-load aborts the load; a pending mem_we is dropped.
// - CHECK_HEADER=0: no compares, errors 1/2/4 never raised; load starts
//   directly in BODY.
// STRUCTURE
// - Shared package/header: WASM magic and version byte constants, error
//   code constants (ERR_NONE..ERR_TRUNC), FSM state encoding
//   (HEADER, BODY, DONE, ERROR).
// - One sub-module: wasm_header_check. Combinational; from index and byte
//   returns match and the error class (magic/version).
// - Top level contains the FSM, address counter and output registers.
// TESTING
// 1 Valid image 00 61 73 6D 01 00 00 00 41 01 0B (last on 0B) ->
//   11 writes at addr 0..10; done=1 and cpu_reset=0 2 cycles after 0B.
// 2 Byte 1 = 0x62 -> error=1; only addr 0 written; in_ready=0.
//   After restart and a valid image -> done=1, error=0.
// 3 Byte 4 = 0x02 -> error=2; addr 0..3 written; cpu_reset stays 1.
// 4 in_last on byte 5 (00 61 73 6D 01 00) -> error=4; 6 writes.
// 5 ADDR_WIDTH=4, 17-byte valid image -> addr 0..15 written, error=3 on
//   byte 17, no write to addr 0 after the first.
// 6 reset pulse after 5 body bytes -> all outputs at reset values next
//   cycle. Reload -> writes restart at START_ADDR.
//   Also: in_valid gaps between bytes -> write timing unchanged.

Source files
------------

// File: rtl/wasm_code_loader_pkg.sv
// Shared constants for the WebAssembly program loader: header bytes,
// error codes and the load FSM state encoding.
package wasm_code_loader_pkg;

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_BODY   = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic [31:0] WASM_MAGIC   = 32'h0061_736D;
    localparam logic [31:0] WASM_VERSION = 32'h0100_0000;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MAGIC    = 3'd1;
    localparam logic [2:0] ERR_VERSION  = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_TRUNC    = 3'd4;

    // Expected header byte at stream position idx (magic first, then version).
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        logic [7:0] b;
        unique case (idx)
            3'd0: b = WASM_MAGIC[31:24];
            3'd1: b = WASM_MAGIC[23:16];
            3'd2: b = WASM_MAGIC[15:8];
            3'd3: b = WASM_MAGIC[7:0];
            3'd4: b = WASM_VERSION[31:24];
            3'd5: b = WASM_VERSION[23:16];
            3'd6: b = WASM_VERSION[15:8];
            default: b = WASM_VERSION[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wasm_header_check.sv
// Combinational compare of one header byte against the WASM magic/version
// pattern; also reports which error class a mismatch at this index belongs to.
module wasm_header_check
    import wasm_code_loader_pkg::*;
(
    input  logic [2:0] index,
    input  logic [7:0] data,
    output logic       match,
    output logic [2:0] err_class
);

    assign match     = (data == hdr_byte(index));
    assign err_class = index[2] ? ERR_VERSION : ERR_MAGIC;

endmodule

// File: rtl/wasm_code_loader.sv
// Streams a WebAssembly image into program memory at sequential addresses,
// validating the 8-byte header and holding the CPU in reset until loaded.
//
//   state  | meaning
//   HEADER | accepting header bytes 0..7, each compared before being written
//   BODY   | accepting and writing code bytes until in_last
//   DONE   | image loaded, cpu released, waiting for restart
//   ERROR  | load aborted, error code held, waiting for restart
module wasm_code_loader
    import wasm_code_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 16,
    parameter int unsigned START_ADDR   = 0,
    parameter bit          CHECK_HEADER = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  cpu_reset,
    output logic                  done,
    output logic [2:0]            error
);

    localparam logic [ADDR_WIDTH-1:0] START      = ADDR_WIDTH'(START_ADDR);
    localparam state_t                LOAD_STATE = CHECK_HEADER ? ST_HEADER : ST_BODY;

    state_t                  state_q, state_d;
    logic [2:0]              index_q, index_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    full_q, full_d;
    logic [2:0]              err_d;
    logic                    accept;
    logic                    wr_en;
    logic                    release_cpu;
    logic                    hdr_match;
    logic [2:0]              hdr_err;

    wasm_header_check u_header_check (
        .index     (index_q),
        .data      (in_data),
        .match     (hdr_match),
        .err_class (hdr_err)
    );

    assign in_ready = (state_q == ST_HEADER) || (state_q == ST_BODY);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        addr_d      = addr_q;
        full_d      = full_q;
        err_d       = error;
        wr_en       = 1'b0;
        release_cpu = (state_q == ST_DONE) && !restart;

        unique case (state_q)
            ST_HEADER: begin
                if (accept) begin
                    if (full_q) begin
                        err_d   = ERR_OVERFLOW;
                        state_d = ST_ERROR;
                    end else if (!hdr_match) begin
                        err_d   = hdr_err;
                        state_d = ST_ERROR;
                    end else begin
                        // A short image is still written up to its last byte.
                        wr_en   = 1'b1;
                        index_d = index_q + 3'd1;
                        if (in_last && (index_q != 3'd7)) begin
                            err_d   = ERR_TRUNC;
                            state_d = ST_ERROR;
                        end else if (index_q == 3'd7) begin
                            state_d = in_last ? ST_DONE : ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    if (full_q) begin
                        err_d   = ERR_OVERFLOW;
                        state_d = ST_ERROR;
                    end else begin
                        wr_en = 1'b1;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_d = LOAD_STATE;
                    index_d = '0;
                    addr_d  = START;
                    full_d  = 1'b0;
                    err_d   = ERR_NONE;
                end
            end
        endcase

        // Top address is written once; afterwards the counter parks instead of wrapping.
        if (wr_en) begin
            if (addr_q == '1) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD_STATE;
            index_q   <= '0;
            addr_q    <= START;
            full_q    <= 1'b0;
            error     <= ERR_NONE;
            mem_we    <= 1'b0;
            mem_addr  <= START;
            mem_data  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            addr_q    <= addr_d;
            full_q    <= full_d;
            error     <= err_d;
            mem_we    <= wr_en;
            if (wr_en) begin
                mem_addr <= addr_q;
                mem_data <= in_data;
            end
            cpu_reset <= !release_cpu;
            done      <= release_cpu;
        end
    end

endmodule

// File: tb/tb_wasm_code_loader.sv
// Self-checking bench for wasm_code_loader: table-driven images, a reset-abort
// sequence and randomized images checked against a byte-list reference model.
`timescale 1ns/1ps
module tb_wasm_code_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, restart, in_valid, in_last;
    logic [7:0] in_data;

    logic        rdy_a, we_a, cr_a, dn_a;  logic [15:0] ad_a; logic [7:0] dt_a; logic [2:0] er_a;
    logic        rdy_b, we_b, cr_b, dn_b;  logic [3:0]  ad_b; logic [7:0] dt_b; logic [2:0] er_b;
    logic        rdy_c, we_c, cr_c, dn_c;  logic [15:0] ad_c; logic [7:0] dt_c; logic [2:0] er_c;

    wasm_code_loader #(.ADDR_WIDTH(16), .START_ADDR(0), .CHECK_HEADER(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_a), .restart(restart), .mem_addr(ad_a), .mem_data(dt_a), .mem_we(we_a),
        .cpu_reset(cr_a), .done(dn_a), .error(er_a));

    wasm_code_loader #(.ADDR_WIDTH(4), .START_ADDR(0), .CHECK_HEADER(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_b), .restart(restart), .mem_addr(ad_b), .mem_data(dt_b), .mem_we(we_b),
        .cpu_reset(cr_b), .done(dn_b), .error(er_b));

    wasm_code_loader #(.ADDR_WIDTH(16), .START_ADDR(32'hFFFA), .CHECK_HEADER(1'b0)) dut_c (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_c), .restart(restart), .mem_addr(ad_c), .mem_data(dt_c), .mem_we(we_c),
        .cpu_reset(cr_c), .done(dn_c), .error(er_c));

    // Selected instance under test
    int          sel;
    logic        s_rdy, s_we, s_cr, s_dn;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    logic [2:0]  s_err;

    always_comb begin
        case (sel)
            1: begin s_rdy = rdy_b; s_we = we_b; s_cr = cr_b; s_dn = dn_b;
                     s_addr = {12'd0, ad_b}; s_data = dt_b; s_err = er_b; end
            2: begin s_rdy = rdy_c; s_we = we_c; s_cr = cr_c; s_dn = dn_c;
                     s_addr = ad_c; s_data = dt_c; s_err = er_c; end
            default: begin s_rdy = rdy_a; s_we = we_a; s_cr = cr_a; s_dn = dn_a;
                     s_addr = ad_a; s_data = dt_a; s_err = er_a; end
        endcase
    end

    function automatic int m_aw(input int s);    return (s == 1) ? 4 : 16; endfunction
    function automatic int m_start(input int s); return (s == 2) ? 32'hFFFA : 0; endfunction
    function automatic bit m_chk(input int s);   return (s != 2); endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    // Reference model: walks the byte list applying the loader's rules.
    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    logic [7:0] hdr_ref [8];
    logic [7:0] img_q [$];
    wr_t        exp_q [$];
    wr_t        got_q [$];
    int         exp_err, exp_cons;
    bit         exp_done;

    function automatic void run_model();
        int addr = m_start(sel);
        int top  = (1 << m_aw(sel)) - 1;
        bit full = 0;
        exp_q.delete();
        exp_err = 0; exp_cons = 0; exp_done = 0;
        for (int i = 0; i < img_q.size(); i++) begin
            exp_cons++;
            if (full) begin exp_err = 3; break; end
            if (m_chk(sel) && i < 8 && img_q[i] != hdr_ref[i]) begin
                exp_err = (i < 4) ? 1 : 2;
                break;
            end
            exp_q.push_back('{a: 16'(addr), d: img_q[i]});
            if (addr == top) full = 1; else addr++;
            if (i == img_q.size() - 1) begin
                if (m_chk(sel) && i < 7) exp_err = 4; else exp_done = 1;
            end
        end
    endfunction

    // Monitor: collects writes and checks write / done latency against acceptances.
    int   cyc = 0;
    bit   mon_en = 0;
    int   last_acc = -100;
    int   last_fin = -100;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_we) begin
                chk("we_timing", cyc, last_acc + 1);
                got_q.push_back('{a: s_addr, d: s_data});
            end
            if (s_dn && !done_prev) chk("done_timing", cyc, last_fin + 2);
            if (in_valid && s_rdy) begin
                last_acc = cyc;
                if (in_last) last_fin = cyc;
            end
        end
        done_prev = s_dn;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_error"}, s_err, 0);
        chk({tag, "_done"}, s_dn, 0);
        chk({tag, "_cpu_reset"}, s_cr, 1);
        chk({tag, "_mem_we"}, s_we, 0);
        chk({tag, "_mem_addr"}, s_addr, m_start(sel));
        chk({tag, "_mem_data"}, s_data, 0);
        chk({tag, "_in_ready"}, s_rdy, 1);
    endtask

    task automatic start_load(input int s, input bit via_restart);
        mon_en = 0;
        sel = s;
        if (via_restart) begin
            restart = 1'b1;
            @(posedge clk); #1;
            restart = 1'b0;
            chk("restart_error", s_err, 0);
            chk("restart_done", s_dn, 0);
            chk("restart_cpu_reset", s_cr, 1);
            chk("restart_in_ready", s_rdy, 1);
        end else begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check_reset_vals("reset");
        end
        got_q.delete();
        last_acc = -100;
        last_fin = -100;
        mon_en = 1;
    endtask

    task automatic feed(input int n, input bit gaps, input bit last_on_end);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int k = $urandom_range(0, 2);
                if (k > 0) begin
                    in_valid = 1'b0; in_last = 1'b0;
                    repeat (k) begin @(posedge clk); #1; end
                end
            end
            in_data  = img_q[i];
            in_valid = 1'b1;
            in_last  = last_on_end && (i == img_q.size() - 1);
            t = 0;
            while (!s_rdy && t < 16) begin @(posedge clk); #1; t++; end
            if (!s_rdy) begin
                chk("ready_timeout", s_rdy, 1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_and_check(input bit gaps, input int terr, input int tnw, input int tdone);
        run_model();
        feed(exp_cons, gaps, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("error", s_err, exp_err);
        chk("done", s_dn, exp_done);
        chk("cpu_reset", s_cr, !exp_done);
        chk("in_ready_after", s_rdy, 0);
        chk("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("write_addr", got_q[i].a, exp_q[i].a);
            chk("write_data", got_q[i].d, exp_q[i].d);
        end
        if (terr >= 0) begin
            chk("tbl_error", s_err, terr);
            chk("tbl_writes", got_q.size(), tnw);
            chk("tbl_done", s_dn, tdone);
        end
    endtask

    typedef struct {
        logic [135:0] img;
        int           len;
        int           sel;
        bit           gaps;
        int           err;
        int           nwr;
        int           done;
    } vec_t;

    function automatic logic [135:0] lj(input logic [135:0] v, input int len);
        return v << (8 * (17 - len));
    endfunction

    vec_t vt [12];

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_sel;
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; sel = 0;
        hdr_ref = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        vt[0]  = '{lj(88'h0061736D01000000_41010B, 11), 11, 0, 0, 0, 11, 1};
        vt[1]  = '{lj(88'h0062736D01000000_41010B, 11), 11, 0, 0, 1, 1, 0};
        vt[2]  = '{lj(88'h0061736D01000000_2021AB, 11), 11, 0, 1, 0, 11, 1};
        vt[3]  = '{lj(88'h0061736D02000000_41010B, 11), 11, 0, 0, 2, 4, 0};
        vt[4]  = '{lj(48'h0061736D0100, 6), 6, 0, 0, 4, 6, 0};
        vt[5]  = '{lj(64'h0061736D01000000, 8), 8, 0, 0, 0, 8, 1};
        vt[6]  = '{lj(88'h0161736D01000000_41010B, 11), 11, 0, 0, 1, 0, 0};
        vt[7]  = '{lj(88'h0061736D01000001_41010B, 11), 11, 0, 1, 2, 7, 0};
        vt[8]  = '{lj(136'h0061736D01000000_0102030405060708_09, 17), 17, 1, 0, 3, 16, 0};
        vt[9]  = '{lj(128'h0061736D01000000_1112131415161718, 16), 16, 1, 1, 0, 16, 1};
        vt[10] = '{lj(40'hDEADBEEF01, 5), 5, 2, 0, 0, 5, 1};
        vt[11] = '{lj(64'h1122334455667788, 8), 8, 2, 0, 3, 6, 0};

        for (int i = 0; i < 12; i++) begin
            start_load(vt[i].sel, (i > 0) && (vt[i].sel == vt[i-1].sel));
            img_q.delete();
            for (int j = 0; j < vt[i].len; j++) img_q.push_back(vt[i].img[135 - 8*j -: 8]);
            load_and_check(vt[i].gaps, vt[i].err, vt[i].nwr, vt[i].done);
        end

        // Reset mid-load: 13 bytes accepted, a 14th presented together with reset.
        start_load(0, 1'b0);
        img_q.delete();
        for (int j = 0; j < 8; j++) img_q.push_back(hdr_ref[j]);
        for (int j = 0; j < 6; j++) img_q.push_back(8'(8'hA0 + j));
        feed(13, 1'b0, 1'b0);
        in_data  = img_q[13];
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("abort");
        chk("abort_writes", got_q.size(), 13);
        start_load(0, 1'b0);
        img_q.delete();
        for (int j = 0; j < 8; j++) img_q.push_back(hdr_ref[j]);
        img_q.push_back(8'h55);
        img_q.push_back(8'h0B);
        load_and_check(1'b0, 0, 10, 1);
        prev_sel = 0;

        for (int k = 0; k < 60; k++) begin
            int s = $urandom_range(0, 2);
            int n = $urandom_range(1, 20);
            bit via_restart = (s == prev_sel) && ($urandom_range(0, 1) == 1);
            start_load(s, via_restart);
            img_q.delete();
            for (int j = 0; j < n; j++) img_q.push_back((j < 8) ? hdr_ref[j] : 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                int idx = $urandom_range(0, 7);
                if (idx < n) img_q[idx] = img_q[idx] ^ 8'($urandom_range(1, 255));
            end
            load_and_check($urandom_range(0, 1) == 1, -1, 0, 0);
            prev_sel = s;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
